// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests under a credit cap,
// matches in-order responses to their PCs and buffers them for IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d;

  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  logic [31:0] pcq_q       [DEPTH];

  logic [SW-1:0] credit_occ;
  logic          credit_ok;
  logic          issue;
  logic          resp;
  logic          pop;
  logic          push;

  // Credits come from registered state only; dropped in-flight requests do not
  // hold a buffer slot but still occupy a PC-queue entry.
  assign credit_occ = SW'(count_q) + SW'(pending_q) - SW'(discard_q);
  assign credit_ok  = (credit_occ < SW'(DEPTH)) && (pending_q < CW'(DEPTH));
  assign imem_req   = !reset && !redirect_i && credit_ok;
  assign issue      = imem_req && imem_ready;
  assign resp       = imem_rvalid && (pending_q != '0);
  assign pop        = (count_q != '0) && !stall_i;

  assign imem_addr    = fetch_pc_q;
  assign inst_valid_o = (count_q != '0);
  assign pc_o         = fifo_pc_q[head_q];
  assign inst_o       = fifo_inst_q[head_q];

  // Next-state: redirect flushes and re-targets, otherwise issue/respond/pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    push       = 1'b0;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      pending_d  = pending_q - CW'(resp);
      discard_d  = pending_d;
      pq_rd_d    = pq_rd_q + PW'(resp);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pq_wr_d    = pq_wr_q + PW'(1);
      end
      if (resp) begin
        pq_rd_d = pq_rd_q + PW'(1);
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      pending_d = pending_q + CW'(issue) - CW'(resp);
      count_d   = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      pending_q  <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      if (issue) begin
        pcq_q[pq_wr_q] <= fetch_pc_q;
      end
      if (push) begin
        fifo_pc_q[tail_q]   <= pcq_q[pq_rd_q];
        fifo_inst_q[tail_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model plus a latency
// configurable in-order instruction memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic drop; } inf_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct packed { logic [31:0] addr; int due; } mem_t;

  inf_t        m_inf[$];
  ent_t        m_fifo[$];
  mem_t        mem_q[$];
  logic [31:0] m_pc;
  int          cyc;
  int          lat;
  bit          stray;
  bit          mem_fire;
  int          total;
  int          bad;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Request allowed when buffered plus live in-flight instructions leave room.
  function automatic bit m_req();
    int live;
    live = 0;
    foreach (m_inf[k]) if (!m_inf[k].drop) live++;
    return !redirect_i && ((m_fifo.size() + live) < DEPTH) && (m_inf.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_mem();
    mem_fire = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (mem_fire) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_q[0].addr);
    end else if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (m_fifo.size() != 0);
    chk("req", 32'(imem_req), 32'(m_req()));
    chk("addr", imem_addr, m_pc);
    chk("valid", 32'(inst_valid_o), 32'(ev));
    if (ev) begin
      chk("pc", pc_o, m_fifo[0].pc);
      chk("inst", inst_o, m_fifo[0].inst);
    end
  endtask

  task automatic model_step();
    bit   req;
    bit   resp;
    inf_t e;
    req  = m_req();
    resp = imem_rvalid && (m_inf.size() > 0);
    if (redirect_i) begin
      m_fifo.delete();
      if (resp) void'(m_inf.pop_front());
      foreach (m_inf[k]) m_inf[k].drop = 1'b1;
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if ((m_fifo.size() > 0) && !stall_i) void'(m_fifo.pop_front());
      if (resp) begin
        e = m_inf.pop_front();
        if (!e.drop) m_fifo.push_back('{pc: e.pc, inst: imem_rdata});
      end
      if (req && imem_ready) begin
        m_inf.push_back('{pc: m_pc, drop: 1'b0});
        mem_q.push_back('{addr: m_pc, due: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
    end
    if (mem_fire) void'(mem_q.pop_front());
  endtask

  // One clock: memory drives, compare at negedge, model advances, realign.
  task automatic cycle();
    drive_mem();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit stray_after);
    reset       = 1'b1;
    redirect_i  = 1'b0;
    stall_i     = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    stray       = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    m_fifo.delete();
    m_inf.delete();
    mem_q.delete();
    m_pc  = RESET_PC;
    cyc   = 0;
    stray = stray_after;
    reset = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1; stray = 1'b0; mem_fire = 1'b0;
    reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    m_pc = RESET_PC;
    @(posedge clk);
    #1;

    // Streaming with single-cycle latency.
    do_reset(1'b0); lat = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) begin chk("t1_addr0", imem_addr, 32'h0); chk("t1_req0", 32'(imem_req), 32'd1); end
      if (i == 1) chk("t1_addr1", imem_addr, 32'h4);
      if (i == 2) begin chk("t1_valid2", 32'(inst_valid_o), 32'd1); chk("t1_pc2", pc_o, 32'h0); end
      if (i == 3) chk("t1_pc3", pc_o, 32'h4);
      if (i == 4) chk("t1_pc4", pc_o, 32'h8);
      cycle();
    end

    // Stall for 10 cycles fills the buffer, then drains in order.
    do_reset(1'b0); lat = 1; stall_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) stall_i = 1'b0;
      #1;
      if (i == 6) begin
        chk("t2_req6", 32'(imem_req), 32'd0);
        chk("t2_pc6", pc_o, 32'h0);
        chk("t2_inst6", inst_o, memf(32'h0));
      end
      if (i == 11) begin chk("t2_addr11", imem_addr, 32'h10); chk("t2_req11", 32'(imem_req), 32'd1); end
      if (i == 13) chk("t2_pc13", pc_o, 32'hC);
      if (i == 14) chk("t2_pc14", pc_o, 32'h10);
      cycle();
    end

    // Memory not ready for 3 cycles at address 8.
    do_reset(1'b0); lat = 1;
    for (int i = 0; i < 12; i++) begin
      imem_ready = !(i >= 2 && i <= 4);
      #1;
      if (i == 3) begin chk("t3_addr3", imem_addr, 32'h8); chk("t3_req3", 32'(imem_req), 32'd1); end
      if (i == 5) chk("t3_addr5", imem_addr, 32'h8);
      if (i == 6) chk("t3_addr6", imem_addr, 32'hC);
      if (i == 7) chk("t3_pc7", pc_o, 32'h8);
      if (i == 8) chk("t3_pc8", pc_o, 32'hC);
      cycle();
    end

    // Redirect with two late responses outstanding.
    do_reset(1'b0); lat = 3;
    for (int i = 0; i < 12; i++) begin
      redirect_i    = (i == 2);
      redirect_pc_i = 32'h0000_0103;
      #1;
      if (i == 2) chk("t4_req2", 32'(imem_req), 32'd0);
      if (i == 3) begin chk("t4_addr3", imem_addr, 32'h100); chk("t4_valid3", 32'(inst_valid_o), 32'd0); end
      if (i == 6) chk("t4_valid6", 32'(inst_valid_o), 32'd0);
      if (i == 7) begin chk("t4_pc7", pc_o, 32'h100); chk("t4_inst7", inst_o, memf(32'h100)); end
      cycle();
    end
    redirect_i = 1'b0;

    // Redirect coinciding with a response and a pop.
    do_reset(1'b0); lat = 2;
    for (int i = 0; i < 12; i++) begin
      redirect_i    = (i == 4);
      redirect_pc_i = 32'h0000_2000;
      #1;
      if (i == 4) begin chk("t5_pc4", pc_o, 32'h4); chk("t5_rvalid4", 32'(imem_rvalid), 32'd1); end
      if (i == 5) begin chk("t5_valid5", 32'(inst_valid_o), 32'd0); chk("t5_addr5", imem_addr, 32'h2000); end
      if (i == 8) begin chk("t5_valid8", 32'(inst_valid_o), 32'd1); chk("t5_pc8", pc_o, 32'h2000); end
      cycle();
    end
    redirect_i = 1'b0;

    // Back-to-back redirects: the later target wins.
    do_reset(1'b0); lat = 2;
    for (int i = 0; i < 12; i++) begin
      redirect_i    = (i == 3) || (i == 4);
      redirect_pc_i = (i == 3) ? 32'h0000_0300 : 32'h0000_0404;
      #1;
      if (i == 4) chk("t6_addr4", imem_addr, 32'h300);
      if (i == 5) chk("t6_addr5", imem_addr, 32'h404);
      if (i == 8) chk("t6_pc8", pc_o, 32'h404);
      cycle();
    end
    redirect_i = 1'b0;

    // Reset pulsed with three requests in flight, then a stray response.
    do_reset(1'b0); lat = 3;
    for (int i = 0; i < 4; i++) cycle();
    chk("t7_pre_valid", 32'(inst_valid_o), 32'd1);
    chk("t7_pre_inst", inst_o, memf(32'h0));
    chk("t7_pre_pend", 32'(m_inf.size()), 32'd3);
    lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) stray = 1'b0;
      #1;
      if (i == 0) begin chk("t7_addr0", imem_addr, RESET_PC); chk("t7_req0", 32'(imem_req), 32'd1); end
      if (i == 1) chk("t7_valid1", 32'(inst_valid_o), 32'd0);
      if (i == 2) begin chk("t7_pc2", pc_o, 32'h0); chk("t7_inst2", inst_o, memf(32'h0)); end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
